cntr_datapath: RTL and testbench

- Counter datapath stage directly downstream of the counter control FSM.
- Consumes the per-cycle operation code (wrap / increment / hold) and owns the 32-bit count register.
- The count register drives the control FSM's count input as feedback.
- Each wrap event is timestamped and queued in a small FIFO, drained over a valid/ready interface toward status/interrupt logic.

---
 rtl/cntr_operations_pkg.sv | 22 ++
 rtl/cntr_evt_fifo.sv | 61 ++++++
 rtl/cntr_datapath.sv | 118 +++++++++++
 tb/tb_cntr_datapath.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cntr_operations_pkg.sv
// ============================================================================
// Module      : cntr_operations (package)
// Description : Operation codes shared by the counter control FSM and the
//               counter datapath, plus the count register width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cntr_operations;

    localparam int CNTR_W = 32;

    // Encoding 2'd0 is not a legal op; the datapath treats it as hold.
    typedef enum logic [1:0] {
        cntr_op_state_1 = 2'd1,   // wrap
        cntr_op_state_2 = 2'd2,   // increment
        cntr_op_state_3 = 2'd3    // hold
    } cntr_operations_t;

endpackage

`default_nettype wire

// File: rtl/cntr_evt_fifo.sv
// ============================================================================
// Module      : cntr_evt_fifo
// Description : Single-clock synchronous FIFO with extra-wrap-bit pointers;
//               a push into a full FIFO is accepted only alongside a pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cntr_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [W-1:0]           i_din,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level,
    output logic [W-1:0]           o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_do_pop;
    logic         w_do_push;

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_din;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_level = r_wptr - r_rptr;
    // Head is read from storage registers through registered pointers only.
    assign o_head  = r_mem[r_rptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/cntr_datapath.sv
// ============================================================================
// Module      : cntr_datapath
// Description : Count register, free-running timestamp and wrap-event FIFO.
//               Optional macro CNTR_BOUNDS_CHK_EN adds the bounds_err output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cntr_datapath
    import cntr_operations::*;
#(
    parameter int WRAP_VALUE = 127,
    parameter int EVT_DEPTH  = 4,
    parameter int STAMP_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  cntr_operations_t           operation,
    output logic [CNTR_W-1:0]          cnt_out,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [STAMP_W-1:0]         evt_data,
    output logic [$clog2(EVT_DEPTH):0] evt_level,
    output logic                       evt_overflow,
    input  logic                       ovf_clr
`ifdef CNTR_BOUNDS_CHK_EN
    ,
    output logic                       bounds_err
`endif
);

    generate
        if (EVT_DEPTH < 2 || EVT_DEPTH > 16 || (EVT_DEPTH & (EVT_DEPTH - 1)) != 0
            || WRAP_VALUE < 0) begin : g_bad_param
            $error("cntr_datapath: illegal EVT_DEPTH or WRAP_VALUE");
        end
    endgenerate

    logic [CNTR_W-1:0]  r_cnt;
    logic [STAMP_W-1:0] r_stamp;
    logic               r_ovf;
    logic               w_wrap;
    logic               w_inc;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;

    assign w_wrap = (operation == cntr_op_state_1);
    assign w_inc  = (operation == cntr_op_state_2);
    assign w_pop  = evt_valid && evt_ready;
    assign w_drop = w_wrap && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_stamp <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_stamp <= r_stamp + 1'b1;
            if (w_wrap) begin
                r_cnt <= '0;
            end else if (w_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    cntr_evt_fifo #(
        .DEPTH (EVT_DEPTH),
        .W     (STAMP_W)
    ) u_evt_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_wrap),
        .i_pop   (w_pop),
        .i_din   (r_stamp),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (evt_level),
        .o_head  (evt_data)
    );

    assign cnt_out      = r_cnt;
    assign evt_valid    = !w_empty;
    assign evt_overflow = r_ovf;

`ifdef CNTR_BOUNDS_CHK_EN
    logic r_bounds_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bounds_err <= 1'b0;
        end else if ((w_wrap && r_cnt != CNTR_W'(WRAP_VALUE)) ||
                     (w_inc  && r_cnt == CNTR_W'(WRAP_VALUE))) begin
            r_bounds_err <= 1'b1;
        end
    end

    assign bounds_err = r_bounds_err;

`ifndef SYNTHESIS
    a_wrap_at_terminal: assert property (@(posedge clk) disable iff (rst)
        (operation == cntr_op_state_1) |-> (r_cnt == CNTR_W'(WRAP_VALUE)));
    a_no_inc_past_terminal: assert property (@(posedge clk) disable iff (rst)
        (operation == cntr_op_state_2) |-> (r_cnt != CNTR_W'(WRAP_VALUE)));
`endif
`endif

endmodule

`default_nettype wire

// File: tb/tb_cntr_datapath.sv
// ============================================================================
// Module      : tb_cntr_datapath
// Description : Self-checking bench for cntr_datapath against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cntr_datapath;
    import cntr_operations::*;

    localparam int DEPTH = 4;
    localparam int SW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    cntr_operations_t  operation = cntr_op_state_3;
    logic [31:0]       cnt_out;
    logic              evt_valid;
    logic              evt_ready = 1'b0;
    logic [SW-1:0]     evt_data;
    logic [LW-1:0]     evt_level;
    logic              evt_overflow;
    logic              ovf_clr = 1'b0;
`ifdef CNTR_BOUNDS_CHK_EN
    logic              bounds_err;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0]   m_cnt   = '0;
    logic [SW-1:0] m_stamp = '0;
    logic [SW-1:0] m_q[$];
    logic          m_ovf   = 1'b0;

    cntr_datapath #(
        .WRAP_VALUE (127),
        .EVT_DEPTH  (DEPTH),
        .STAMP_W    (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .operation    (operation),
        .cnt_out      (cnt_out),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .evt_level    (evt_level),
        .evt_overflow (evt_overflow),
        .ovf_clr      (ovf_clr)
`ifdef CNTR_BOUNDS_CHK_EN
        ,
        .bounds_err   (bounds_err)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; the model applies the same inputs the DUT sampled.
    task automatic tick();
        bit pop;
        bit drop;
        @(posedge clk);
        if (rst) begin
            m_cnt = '0;
            m_stamp = '0;
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            pop  = (m_q.size() != 0) && evt_ready;
            drop = (operation == cntr_op_state_1) && (m_q.size() == DEPTH) && !pop;
            if (pop) void'(m_q.pop_front());
            if (operation == cntr_op_state_1 && !drop) m_q.push_back(m_stamp);
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (operation == cntr_op_state_1) m_cnt = '0;
            else if (operation == cntr_op_state_2) m_cnt = m_cnt + 1;
            m_stamp = m_stamp + 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (cnt_out !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0h exp=0", cnt_out); end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
        total++; if (evt_level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", evt_level); end
        total++; if (evt_data !== '0) begin bad++; $display("FAIL reset_data got=%0h exp=0", evt_data); end
        total++; if (evt_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", evt_overflow); end
    endtask

    task automatic test_increment();
        operation = cntr_op_state_2;
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (cnt_out !== 32'(i) || evt_valid !== 1'b0) begin
                bad++;
                $display("FAIL incr_%0d got cnt=%0d valid=%b exp cnt=%0d valid=0", i, cnt_out, evt_valid, i);
            end
        end
    endtask

    task automatic test_wrap_event();
        operation = cntr_op_state_2;
        for (int i = 0; i < 200 && m_cnt != 32'd127; i++) tick();
        total++; if (cnt_out !== 32'd127) begin bad++; $display("FAIL reach_127 got=%0d exp=127", cnt_out); end
        operation = cntr_op_state_3;
        for (int i = 0; i < 20 && m_stamp != SW'(130); i++) tick();
        operation = cntr_op_state_1;
        tick();
        operation = cntr_op_state_3;
        total++; if (cnt_out !== 32'd0) begin bad++; $display("FAIL wrap_cnt got=%0d exp=0", cnt_out); end
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", evt_valid); end
        total++; if (evt_data !== SW'(130)) begin bad++; $display("FAIL wrap_stamp got=%0d exp=130", evt_data); end
        total++; if (evt_level !== LW'(1)) begin bad++; $display("FAIL wrap_level got=%0d exp=1", evt_level); end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL pop_valid got=%b exp=0", evt_valid); end
    endtask

    task automatic test_overflow();
        logic [SW-1:0] first;
        evt_ready = 1'b0;
        first = m_stamp;
        operation = cntr_op_state_1;
        for (int i = 0; i < 5; i++) tick();
        operation = cntr_op_state_3;
        total++; if (evt_level !== LW'(4)) begin bad++; $display("FAIL ovf_level got=%0d exp=4", evt_level); end
        total++; if (evt_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", evt_overflow); end
        total++; if (evt_data !== first) begin bad++; $display("FAIL ovf_head got=%0d exp=%0d", evt_data, first); end
        tick();
        total++; if (evt_data !== first) begin bad++; $display("FAIL head_stable got=%0d exp=%0d", evt_data, first); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        total++; if (evt_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", evt_overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [SW-1:0] pushed;
        logic [SW-1:0] exp_q[$];
        exp_q = m_q;
        pushed = m_stamp;
        void'(exp_q.pop_front());
        exp_q.push_back(pushed);
        evt_ready = 1'b1;
        operation = cntr_op_state_1;
        tick();
        operation = cntr_op_state_3;
        total++; if (evt_level !== LW'(4)) begin bad++; $display("FAIL fullpp_level got=%0d exp=4", evt_level); end
        total++; if (evt_overflow !== 1'b0) begin bad++; $display("FAIL fullpp_ovf got=%b exp=0", evt_overflow); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (evt_valid !== 1'b1 || evt_data !== exp_q[i]) begin
                bad++;
                $display("FAIL drain_%0d got valid=%b data=%0d exp valid=1 data=%0d", i, evt_valid, evt_data, exp_q[i]);
            end
            tick();
        end
        evt_ready = 1'b0;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", evt_valid); end
    endtask

    task automatic test_rollover();
        operation = cntr_op_state_3;
        force dut.r_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_cnt;
        m_cnt = 32'hFFFF_FFFF;
        #1;
        total++; if (cnt_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL preload got=%0h exp=ffffffff", cnt_out); end
        operation = cntr_op_state_2;
        tick();
        total++;
        if (cnt_out !== 32'd0 || evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL rollover got cnt=%0h valid=%b exp cnt=0 valid=0", cnt_out, evt_valid);
        end
        operation = cntr_op_state_3;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (cnt_out !== 32'd0) begin bad++; $display("FAIL hold_%0d got=%0h exp=0", i, cnt_out); end
        end
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        operation = cntr_op_state_1;
        for (int i = 0; i < 3; i++) tick();
        operation = cntr_op_state_2;
        for (int i = 0; i < 50; i++) tick();
        total++;
        if (cnt_out !== 32'd50 || evt_level !== LW'(3)) begin
            bad++;
            $display("FAIL pre_rst got cnt=%0d level=%0d exp cnt=50 level=3", cnt_out, evt_level);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        operation = cntr_op_state_3;
        total++;
        if (evt_level !== '0 || evt_valid !== 1'b0 || cnt_out !== 32'd0) begin
            bad++;
            $display("FAIL mid_rst got level=%0d valid=%b cnt=%0d exp 0/0/0", evt_level, evt_valid, cnt_out);
        end
    endtask

`ifdef CNTR_BOUNDS_CHK_EN
    task automatic test_bounds();
        operation = cntr_op_state_2;
        for (int i = 0; i < 10; i++) tick();
        total++; if (bounds_err !== 1'b0) begin bad++; $display("FAIL bounds_clean got=%b exp=0", bounds_err); end
        operation = cntr_op_state_1;
        tick();
        operation = cntr_op_state_3;
        tick();
        total++; if (bounds_err !== 1'b1) begin bad++; $display("FAIL bounds_err got=%b exp=1", bounds_err); end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            operation = cntr_operations_t'($urandom_range(0, 3));
            evt_ready = ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
            total++;
            if (cnt_out !== m_cnt || evt_valid !== (m_q.size() != 0) ||
                evt_level !== LW'(m_q.size()) || evt_overflow !== m_ovf ||
                (m_q.size() != 0 && evt_data !== m_q[0])) begin
                bad++;
                $display("FAIL rand_%0d got cnt=%0h lvl=%0d ovf=%b data=%0h exp cnt=%0h lvl=%0d ovf=%b data=%0h",
                         n, cnt_out, evt_level, evt_overflow, evt_data, m_cnt, m_q.size(), m_ovf,
                         (m_q.size() != 0) ? m_q[0] : SW'(0));
            end
        end
        rst = 1'b0;
        ovf_clr = 1'b0;
        evt_ready = 1'b0;
        operation = cntr_op_state_3;
    endtask

    initial begin
        test_reset();
        test_increment();
        test_wrap_event();
        test_overflow();
        test_full_push_pop();
        test_rollover();
        test_reset_mid();
`ifdef CNTR_BOUNDS_CHK_EN
        test_bounds();
`else
        test_random();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
